// File: rtl/c7b_csr_soc_top.sv
// rtl/c7b_csr_soc_top.sv - LA32 subset core with internal CSR test ROM, one commit per clock
// Optional macro CSR_SAVE_EXT_EN adds SAVE1..SAVE3 (CSR 0x31..0x33).

module c7b_regfile (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs[raddr_b_i];
endmodule

module c7b_csr (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] num_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [31:0] wdata_i
);
    localparam logic [13:0] CSR_SAVE0 = 14'h030;
    localparam logic [13:0] CSR_SAVE1 = 14'h031;
    localparam logic [13:0] CSR_SAVE2 = 14'h032;
    localparam logic [13:0] CSR_SAVE3 = 14'h033;

    logic [31:0] save0_q;
`ifdef CSR_SAVE_EXT_EN
    logic [31:0] save1_q;
    logic [31:0] save2_q;
    logic [31:0] save3_q;
`endif

    // Unimplemented numbers read as zero.
    always_comb begin
        rdata_o = '0;
        case (num_i)
            CSR_SAVE0: rdata_o = save0_q;
`ifdef CSR_SAVE_EXT_EN
            CSR_SAVE1: rdata_o = save1_q;
            CSR_SAVE2: rdata_o = save2_q;
            CSR_SAVE3: rdata_o = save3_q;
`endif
            default:   rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            save0_q <= '0;
`ifdef CSR_SAVE_EXT_EN
            save1_q <= '0;
            save2_q <= '0;
            save3_q <= '0;
`endif
        end else if (we_i) begin
            case (num_i)
                CSR_SAVE0: save0_q <= wdata_i;
`ifdef CSR_SAVE_EXT_EN
                CSR_SAVE1: save1_q <= wdata_i;
                CSR_SAVE2: save2_q <= wdata_i;
                CSR_SAVE3: save3_q <= wdata_i;
`endif
                default: ;
            endcase
        end
    end
endmodule

module c7b_exu (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [13:0] csr_num;
    logic [31:0] rj_val;
    logic [31:0] rd_val;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        csr_we;
    logic [31:0] si12_sext;
    logic [31:0] br_offs;

    assign rd        = inst_i[4:0];
    assign rj        = inst_i[9:5];
    assign csr_num   = inst_i[23:10];
    assign si12_sext = {{20{inst_i[21]}}, inst_i[21:10]};
    assign br_offs   = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};

    c7b_regfile registers (
        .clk       (clk),
        .resetn    (resetn),
        .raddr_a_i (rj),
        .rdata_a_o (rj_val),
        .raddr_b_i (rd),
        .rdata_b_o (rd_val),
        .we_i      (rf_we_o),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata_o)
    );

    c7b_csr u_csr (
        .clk     (clk),
        .resetn  (resetn),
        .num_i   (csr_num),
        .rdata_o (csr_old),
        .we_i    (csr_we),
        .wdata_i (csr_new)
    );

    // Old and new CSR values both derive from pre-edge GPR/CSR state, so rd==rj needs no special case.
    always_comb begin
        next_pc_o  = pc_i + 32'd4;
        rf_we_o    = 1'b0;
        rf_wdata_o = '0;
        csr_we     = 1'b0;
        csr_new    = csr_old;
        if (inst_i[31:22] == 10'h00a) begin
            rf_we_o    = 1'b1;
            rf_wdata_o = rj_val + si12_sext;
        end else if (inst_i[31:25] == 7'h0a) begin
            rf_we_o    = 1'b1;
            rf_wdata_o = {inst_i[24:5], 12'h000};
        end else if (inst_i[31:26] == 6'h14) begin
            next_pc_o  = pc_i + br_offs;
        end else if (inst_i[31:24] == 8'h04) begin
            rf_we_o    = 1'b1;
            rf_wdata_o = csr_old;
            if (rj == 5'd1) begin
                csr_we  = 1'b1;
                csr_new = rd_val;
            end else if (rj != 5'd0) begin
                csr_we  = 1'b1;
                csr_new = (csr_old & ~rj_val) | (rd_val & rj_val);
            end
        end
        if (rd == 5'd0) begin
            rf_we_o = 1'b0;
        end
    end

    assign rf_waddr_o = rd;
endmodule

module c7b_core #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          ROM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] debug_pc_o,
    output logic        debug_wen_o,
    output logic [4:0]  debug_wnum_o,
    output logic [31:0] debug_wdata_o
);
    localparam logic [31:0] NOP       = 32'h03400000;
    localparam logic [29:0] ROM_WORDS = 30'(ROM_DEPTH);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ifu_exu_pc_w;
    logic [29:0] rom_idx;
    logic [31:0] fetch_inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wen_q;
    logic [4:0]  wnum_q;
    logic [31:0] wdata_q;

    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        case (idx)
            30'd0:   rom_word = 32'h02816805;
            30'd1:   rom_word = 32'h0400c025;
            30'd2:   rom_word = 32'h02801805;
            30'd3:   rom_word = 32'h02803c09;
            30'd4:   rom_word = 32'h0400c125;
            30'd5:   rom_word = 32'h0400c008;
            30'd6:   rom_word = 32'h50000000;
            default: rom_word = NOP;
        endcase
    endfunction

    // Byte offset bits are dropped; addresses below RESET_PC wrap to a large index and read NOP.
    assign rom_idx    = pc_q[31:2] - RESET_PC[31:2];
    assign fetch_inst = (rom_idx < ROM_WORDS) ? rom_word(rom_idx) : NOP;

    c7b_exu exu (
        .clk        (clk),
        .resetn     (resetn),
        .inst_i     (fetch_inst),
        .pc_i       (pc_q),
        .next_pc_o  (pc_d),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q         <= RESET_PC;
            ifu_exu_pc_w <= '0;
            wen_q        <= 1'b0;
            wnum_q       <= '0;
            wdata_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            ifu_exu_pc_w <= pc_q;
            wen_q        <= rf_we;
            wnum_q       <= rf_we ? rf_waddr : 5'd0;
            wdata_q      <= rf_we ? rf_wdata : 32'd0;
        end
    end

    assign debug_pc_o    = ifu_exu_pc_w;
    assign debug_wen_o   = wen_q;
    assign debug_wnum_o  = wnum_q;
    assign debug_wdata_o = wdata_q;
endmodule

module c7b_csr_soc_top #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          ROM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    c7b_core #(
        .RESET_PC  (RESET_PC),
        .ROM_DEPTH (ROM_DEPTH)
    ) u_core (
        .clk           (clk),
        .resetn        (resetn),
        .debug_pc_o    (debug_wb_pc),
        .debug_wen_o   (debug_wb_rf_wen),
        .debug_wnum_o  (debug_wb_rf_wnum),
        .debug_wdata_o (debug_wb_rf_wdata)
    );
endmodule

// File: tb/tb_c7b_csr_soc_top.sv
// tb/tb_c7b_csr_soc_top.sv - bench for c7b_csr_soc_top against an instruction-level reference model
module tb_c7b_csr_soc_top;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP      = 32'h03400000;
`ifdef CSR_SAVE_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    c7b_csr_soc_top u_c7b (
        .clk               (clk),
        .resetn            (resetn),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:6];
    logic [31:0] m_gpr [0:31];
    logic [31:0] m_save [0:3];
    logic [31:0] m_pc;
    logic [31:0] m_pc_w;
    logic        m_wen;
    logic [4:0]  m_wnum;
    logic [31:0] m_wdata;
    logic [31:0] force_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        for (int i = 0; i < 4; i++) m_save[i] = 32'd0;
        m_pc = RESET_PC;
        m_pc_w = 32'd0;
        m_wen = 1'b0;
        m_wnum = 5'd0;
        m_wdata = 32'd0;
    endtask

    function automatic logic [31:0] rom_fetch(input logic [31:0] pc);
        int unsigned word;
        word = (pc - RESET_PC) / 4;
        if (word < 7) return prog[word];
        return NOP;
    endfunction

    function automatic bit csr_exists(input int num);
        return (num == 'h30) || (EXT && num >= 'h31 && num <= 'h33);
    endfunction

    task automatic model_step(input logic [31:0] inst);
        int rd, rj, num, si, offs;
        logic [31:0] a, d, old, res, npc;
        bit writes;
        rd = int'(inst[4:0]);
        rj = int'(inst[9:5]);
        a = m_gpr[rj];
        d = m_gpr[rd];
        npc = m_pc + 32'd4;
        writes = 1'b0;
        res = 32'd0;
        if ((inst >> 22) == 32'h00a) begin
            si = int'(inst[21:10]);
            if (si >= 2048) si -= 4096;
            res = a + 32'(si);
            writes = 1'b1;
        end else if ((inst >> 25) == 32'h0a) begin
            res = (inst >> 5) << 12;
            writes = 1'b1;
        end else if ((inst >> 26) == 32'h14) begin
            offs = int'({inst[9:0], inst[25:10]});
            if (offs >= (1 << 25)) offs -= (1 << 26);
            npc = m_pc + 32'(offs * 4);
        end else if ((inst >> 24) == 32'h04) begin
            num = int'(inst[23:10]);
            old = csr_exists(num) ? m_save[num - 'h30] : 32'd0;
            res = old;
            writes = 1'b1;
            if (rj != 0 && csr_exists(num)) begin
                if (rj == 1) m_save[num - 'h30] = d;
                else m_save[num - 'h30] = (old & ~a) | (d & a);
            end
        end
        m_wen = writes && (rd != 0);
        m_wnum = 5'(rd);
        m_wdata = res;
        if (m_wen) m_gpr[rd] = res;
        m_pc_w = m_pc;
        m_pc = npc;
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".pc_w"}, u_c7b.u_core.ifu_exu_pc_w, m_pc_w);
        check({tag, ".wb_pc"}, debug_wb_pc, m_pc_w);
        check({tag, ".wen"}, {31'd0, debug_wb_rf_wen}, {31'd0, m_wen});
        if (m_wen) begin
            check({tag, ".wnum"}, {27'd0, debug_wb_rf_wnum}, {27'd0, m_wnum});
            check({tag, ".wdata"}, debug_wb_rf_wdata, m_wdata);
        end
        check({tag, ".r5"}, u_c7b.u_core.exu.registers.regs[5], m_gpr[5]);
        check({tag, ".r8"}, u_c7b.u_core.exu.registers.regs[8], m_gpr[8]);
        check({tag, ".r9"}, u_c7b.u_core.exu.registers.regs[9], m_gpr[9]);
    endtask

    // One commit edge; the forced instruction (if any) is already applied by the caller.
    task automatic tick(input bit frc, input logic [31:0] finst);
        logic [31:0] inst;
        inst = frc ? finst : rom_fetch(m_pc);
        @(posedge clk);
        model_step(inst);
        @(negedge clk);
        compare_state("step");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc_w"}, u_c7b.u_core.ifu_exu_pc_w, 32'd0);
        check({tag, ".wen"}, {31'd0, debug_wb_rf_wen}, 32'd0);
        check({tag, ".wnum"}, {27'd0, debug_wb_rf_wnum}, 32'd0);
        check({tag, ".wdata"}, debug_wb_rf_wdata, 32'd0);
        for (int i = 0; i < 32; i++)
            check({tag, ".reg"}, u_c7b.u_core.exu.registers.regs[i], 32'd0);
    endtask

    task automatic check_final(input string tag);
        check({tag, ".pc_w"}, debug_wb_pc, 32'h1c000018);
        check({tag, ".r5"}, u_c7b.u_core.exu.registers.regs[5], 32'h0000005a);
        check({tag, ".r8"}, u_c7b.u_core.exu.registers.regs[8], 32'h00000056);
        check({tag, ".r9"}, u_c7b.u_core.exu.registers.regs[9], 32'h0000000f);
    endtask

    initial begin
        logic [31:0] exp_save1;
        logic [31:0] rinst;
        int n;
        prog[0] = 32'h02816805; prog[1] = 32'h0400c025; prog[2] = 32'h02801805;
        prog[3] = 32'h02803c09; prog[4] = 32'h0400c125; prog[5] = 32'h0400c008;
        prog[6] = 32'h50000000;
        force_val = 32'd0;
        model_reset();
        resetn = 1'b0;
        #32;
        check_reset_state("reset");
        resetn = 1'b1;

        tick(1'b0, 32'd0);
        check("e1.pc", debug_wb_pc, 32'h1c000000);
        check("e1.wen", {31'd0, debug_wb_rf_wen}, 32'd1);
        check("e1.wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
        check("e1.wdata", debug_wb_rf_wdata, 32'h5a);
        tick(1'b0, 32'd0);
        check("e2.wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
        check("e2.wdata", debug_wb_rf_wdata, 32'd0);
        tick(1'b0, 32'd0);
        tick(1'b0, 32'd0);
        tick(1'b0, 32'd0);
        check("e5.wdata", debug_wb_rf_wdata, 32'h5a);
        tick(1'b0, 32'd0);
        check("e6.wdata", debug_wb_rf_wdata, 32'h56);
        tick(1'b0, 32'd0);
        check_final("final");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0);
            check("loop.pc_w", debug_wb_pc, 32'h1c000018);
        end

        // Asynchronous reset at random points, then the program must rerun to the same result.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) tick(1'b0, 32'd0);
            #($urandom_range(1, 3));
            resetn = 1'b0;
            #1;
            model_reset();
            check_reset_state("midreset");
            @(negedge clk);
            check_reset_state("hold");
            resetn = 1'b1;
            for (int k = 0; k < 7; k++) tick(1'b0, 32'd0);
            check_final("rerun");
        end

        // Extended save registers through forced csrwr/csrrd.
        exp_save1 = EXT ? 32'h5a : 32'd0;
        force_val = 32'h0400c425;
        force u_c7b.u_core.fetch_inst = force_val;
        tick(1'b1, force_val);
        check("save1.wr_old", debug_wb_rf_wdata, 32'd0);
        force_val = 32'h0400c408;
        tick(1'b1, force_val);
        check("save1.rd", debug_wb_rf_wdata, exp_save1);
        check("save1.r8", u_c7b.u_core.exu.registers.regs[8], exp_save1);

        // Random forced instructions covering all opcode classes and CSR numbers.
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: rinst = {10'h00a, 12'($urandom), 5'($urandom_range(0, 10)), 5'($urandom_range(0, 10))};
                1: rinst = {7'h0a, 20'($urandom), 5'($urandom_range(0, 10))};
                2: rinst = {8'h04, 14'($urandom_range('h2f, 'h34)), 5'($urandom_range(0, 10)),
                            5'($urandom_range(0, 10))};
                default: rinst = $urandom;
            endcase
            force_val = rinst;
            tick(1'b1, force_val);
        end
        release u_c7b.u_core.fetch_inst;
        for (int k = 0; k < 24; k++) tick(1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
